frame_deframer: RTL
===================

Name: frame_deframer

Overview:
- Receiving end of the framing output stream.
- Input stream: each element held for CADENCE_CYC cycles under a continuous valid, with last marking the final element of a frame.
- The block samples each element exactly once and checks frame length against last. It collects complete frames into a ping-pong buffer.
- It replays each frame as a one-element-per-cycle valid/ready stream. Placed after the framer on bring-up and test paths, and ahead of any back-pressured frame consumer.

Parameters:
- I_BW, 16, input sample width (signed).
- O_BW, 16, output width; O_BW >= I_BW; output is sign-extended.
- FRAME_LEN, 256, elements per frame; >= 2.
- CADENCE_CYC, 3, cycles each input element is held; >= 2.

Ports:
- clk_i  input  1  clock.
- rst_n_i  input  1  reset; asynchronous, active-low.
- en_i  input  1  enable; low = synchronous clear of all state, same effect as reset.
- data_i  input  I_BW  signed input element.
- valid_i  input  1  input valid; high continuously while a frame is being unloaded.
- last_i  input  1  one-cycle pulse on the final cycle of the last element.
- data_o  output  O_BW  signed output element.
- valid_o  output  1  output valid.
- ready_i  input  1  downstream ready.
- last_o  output  1  high with the final element of an output frame.
- err_o  output  1  one-cycle framing/overflow error pulse.

Behaviour:
- Reset or en_i low:
  - Counters, bank-full flags and FSMs go to 0 / idle.
  - data_o=0, valid_o=0, last_o=0, err_o=0.
  - Buffer contents are don't-care.
- Cadence sampler:
  - cad_cnt clears whenever valid_i=0.
  - Otherwise cad_cnt increments. At CADENCE_CYC-1 it asserts strobe and wraps to 0.
  - Each element is captured on its final held cycle, the cycle on which the upstream dequeues.
- Write FSM states: FILL, DROP.
- FILL, on each strobe:
  - Write data_i to bank wr_bank at wr_idx.
  - strobe & last_i & wr_idx==FRAME_LEN-1: set full[wr_bank], toggle wr_bank, wr_idx=0.
  - strobe & last_i & wr_idx<FRAME_LEN-1 (short frame): err_o pulse, wr_idx=0, bank not marked full.
  - strobe & !last_i & wr_idx==FRAME_LEN-1 (long frame): err_o pulse, go to DROP.
  - strobe & wr_idx==0 & full[wr_bank] (overflow): err_o pulse, go to DROP, nothing written.
- DROP:
  - Discard strobes.
  - On strobe & last_i, return to FILL with wr_idx=0.
- last_i on a non-strobe cycle, or with valid_i=0: err_o pulse. The cycle is otherwise ignored.
- At most one err_o pulse per cycle.
- Read FSM states: IDLE, STREAM.
- IDLE:
  - When full[rd_bank], issue a synchronous RAM read at rd_idx=0 and go to STREAM.
  - First valid_o occurs 2 cycles after the cycle full is set.
- STREAM:
  - A 2-entry skid/output register keeps data_o, last_o stable while valid_o & !ready_i.
  - RAM reads are issued only when the skid has space.
  - Sustained throughput: 1 element/cycle with ready_i held high.
  - last_o is high with element FRAME_LEN-1.
  - On that element's handshake: clear full[rd_bank], toggle rd_bank, go to IDLE. If the other bank is already full, chain directly into the next frame with no gap cycle.
- Same-cycle events:
  - Write setting full[x] and read clearing full[y] in the same cycle are independent (x != y always).
  - A write-side overflow check sees the pre-clear flag value, so a frame whose first strobe coincides with the read clear is dropped.
- Widths:
  - wr_idx, rd_idx: $clog2(FRAME_LEN).
  - cad_cnt: $clog2(CADENCE_CYC).
  - data_o = sign-extended RAM word.

Decomposition:
- Shared package holds:
  - FSM encodings: FILL/DROP, IDLE/STREAM.
  - Default FRAME_LEN and CADENCE_CYC.
  - Widths shared with the framer: I_BW=9 at preemphasis, 16 at FFT.
- One sub-module: frame_bank_ram.
  - 2*FRAME_LEN x I_BW, one write port, one synchronous read port.
  - Address is {bank, idx}.

Test Plan:
- Nominal (FRAME_LEN=8, CADENCE_CYC=3): stimulus is 8 elements 1..8, each held 3 cycles, last_i on cycle 24, ready_i=1. Required response: data_o 1..8 on 8 consecutive cycles, last_o with 8, err_o never.
- Back-pressure: same frame, ready_i toggles 1,0,0,1,... Required response: every element appears exactly once, in order; data_o held stable while ready_i=0.
- Short frame: last_i on element 5. Required response: err_o one pulse; no output frame. The next good frame 10..17 streams correctly.
- Long frame: 9 elements, last_i on the 9th. Required response: err_o on the 8th strobe; frame dropped; sampler resynchronises on the next frame.
- Overflow: ready_i=0 while 3 good frames A, B, C arrive. Required response: err_o at C's first strobe; C dropped. Raising ready_i outputs A then B back-to-back.
- Reset mid-stream: rst_n_i low during element 4 of the output stream. Required response: valid_o, last_o, err_o go to 0 immediately (asynchronous). The next complete frame streams correctly.

Source files
------------

// File: rtl/frame_deframer_pkg.sv
// frame_deframer_pkg: state encodings and default sizes shared by the framer/deframer pair.
package frame_deframer_pkg;
    typedef enum logic {FILL = 1'b0, DROP = 1'b1} wr_state_t;
    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} rd_state_t;
    localparam int DEF_FRAME_LEN = 256;
    localparam int DEF_CADENCE_CYC = 3;
    localparam int PRE_BW = 9;
    localparam int FFT_BW = 16;
    function automatic int stage_bw(input logic fft);
        return fft ? FFT_BW : PRE_BW;
    endfunction
endpackage

// File: rtl/frame_deframer_if.sv
// frame_deframer_if: cadenced input stream plus valid/ready replay stream of the deframer.
interface frame_deframer_if #(
    parameter int I_BW = 16,
    parameter int O_BW = 16
);
    logic [I_BW-1:0] data_i;
    logic            valid_i;
    logic            last_i;
    logic [O_BW-1:0] data_o;
    logic            valid_o;
    logic            ready_i;
    logic            last_o;
    modport master (output data_i, valid_i, last_i, ready_i, input data_o, valid_o, last_o);
    modport slave  (input data_i, valid_i, last_i, ready_i, output data_o, valid_o, last_o);
endinterface

// File: rtl/frame_deframer_ram.sv
// frame_bank_ram: two frame banks addressed as {bank, idx}; one write port, one registered read port.
module frame_bank_ram #(
    parameter int I_BW = 16,
    parameter int FRAME_LEN = 256,
    localparam int AW = $clog2(FRAME_LEN) + 1
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_waddr,
    input  logic [I_BW-1:0] i_wdata,
    input  logic            i_re,
    input  logic [AW-1:0]   i_raddr,
    output logic [I_BW-1:0] o_rdata
);
    logic [I_BW-1:0] r_mem [2**AW];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/frame_deframer.sv
// frame_deframer: samples each cadenced element once, checks frame length against last,
// buffers whole frames in two banks and replays them one element per cycle over valid/ready.
module frame_deframer
    import frame_deframer_pkg::*;
#(
    parameter int I_BW = stage_bw(1'b1),
    parameter int O_BW = FFT_BW,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CADENCE_CYC = DEF_CADENCE_CYC
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    output logic err_o,
    frame_deframer_if.slave bus
);
    localparam int IW = $clog2(FRAME_LEN);
    localparam int CW = $clog2(CADENCE_CYC);
    localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);

    logic [CW-1:0]   r_cad;
    wr_state_t       r_wr_st;
    wr_state_t       w_wr_nxt;
    rd_state_t       r_rd_st;
    rd_state_t       w_rd_nxt;
    logic [IW-1:0]   r_wr_idx;
    logic [IW-1:0]   w_wr_idx_nxt;
    logic [IW-1:0]   r_rd_idx;
    logic [IW-1:0]   w_rd_idx_nxt;
    logic            r_wr_bank;
    logic            w_wr_bank_nxt;
    logic            r_rd_bank;
    logic            w_rd_bank_nxt;
    logic            r_out_bank;
    logic [1:0]      r_full;
    logic            r_err;
    logic            r_pend;
    logic            r_pend_last;
    logic            w_stb;
    logic            w_we;
    logic            w_set;
    logic            w_err;
    logic            w_re;
    logic            w_space;
    logic            w_pop;
    logic            w_clr;
    logic            w_avail_cur;
    logic            w_avail_nxt;
    logic [I_BW-1:0] w_q;
    logic [I_BW-1:0] r_dat [2];
    logic [1:0]      r_lst;
    logic            r_wp;
    logic            r_rp;
    logic [1:0]      r_cnt;
    logic [2:0]      w_occ;

    // the upstream dequeues on the final held cycle, so that is the one sampled
    assign w_stb = bus.valid_i && (r_cad == CW'(CADENCE_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_cad <= '0;
        else r_cad <= (!en_i || !bus.valid_i || w_stb) ? '0 : r_cad + CW'(1);
    end

    always_comb begin
        w_wr_nxt = r_wr_st;
        w_wr_idx_nxt = r_wr_idx;
        w_wr_bank_nxt = r_wr_bank;
        w_we = 1'b0;
        w_set = 1'b0;
        w_err = bus.last_i && !w_stb;
        if (w_stb) begin
            if (r_wr_st == DROP) begin
                w_wr_nxt = bus.last_i ? FILL : DROP;
                w_wr_idx_nxt = '0;
            end else if (r_wr_idx == '0 && r_full[r_wr_bank]) begin
                w_err = 1'b1;
                w_wr_nxt = bus.last_i ? FILL : DROP;
            end else begin
                w_we = 1'b1;
                if (bus.last_i) begin
                    w_set = r_wr_idx == LAST;
                    w_err = !w_set;
                    w_wr_idx_nxt = '0;
                    w_wr_bank_nxt = r_wr_bank ^ w_set;
                end else if (r_wr_idx == LAST) begin
                    w_err = 1'b1;
                    w_wr_nxt = DROP;
                    w_wr_idx_nxt = '0;
                end else begin
                    w_wr_idx_nxt = r_wr_idx + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_st <= FILL;
            r_wr_idx <= '0;
            r_wr_bank <= 1'b0;
            r_err <= 1'b0;
        end else if (!en_i) begin
            r_wr_st <= FILL;
            r_wr_idx <= '0;
            r_wr_bank <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_wr_st <= w_wr_nxt;
            r_wr_idx <= w_wr_idx_nxt;
            r_wr_bank <= w_wr_bank_nxt;
            r_err <= w_err;
        end
    end

    // set and clear always target different banks, so both may land in one cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_full <= '0;
        end else if (!en_i) begin
            r_full <= '0;
        end else begin
            if (w_set) r_full[r_wr_bank] <= 1'b1;
            if (w_clr) r_full[r_out_bank] <= 1'b0;
        end
    end

    assign w_pop = (r_cnt != 2'd0) && bus.ready_i;
    assign w_clr = w_pop && r_lst[r_rp];
    assign w_occ = 3'(r_cnt) + 3'(r_pend) - 3'(w_pop);
    assign w_space = w_occ < 3'd2;
    // a bank whose last element hands off this cycle is not yet free to read again
    assign w_avail_cur = r_full[r_rd_bank] && !(w_clr && r_out_bank == r_rd_bank);
    assign w_avail_nxt = r_full[~r_rd_bank] && !(w_clr && r_out_bank != r_rd_bank);

    always_comb begin
        w_rd_nxt = r_rd_st;
        w_rd_idx_nxt = r_rd_idx;
        w_rd_bank_nxt = r_rd_bank;
        w_re = 1'b0;
        if (r_rd_st == IDLE) begin
            if (w_avail_cur && w_space) begin
                w_re = 1'b1;
                w_rd_idx_nxt = r_rd_idx + IW'(1);
                w_rd_nxt = STREAM;
            end
        end else if (w_space) begin
            w_re = 1'b1;
            if (r_rd_idx == LAST) begin
                w_rd_idx_nxt = '0;
                w_rd_bank_nxt = ~r_rd_bank;
                w_rd_nxt = w_avail_nxt ? STREAM : IDLE;
            end else begin
                w_rd_idx_nxt = r_rd_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_st <= IDLE;
            r_rd_idx <= '0;
            r_rd_bank <= 1'b0;
            r_pend <= 1'b0;
            r_pend_last <= 1'b0;
        end else if (!en_i) begin
            r_rd_st <= IDLE;
            r_rd_idx <= '0;
            r_rd_bank <= 1'b0;
            r_pend <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            r_rd_st <= w_rd_nxt;
            r_rd_idx <= w_rd_idx_nxt;
            r_rd_bank <= w_rd_bank_nxt;
            r_pend <= w_re;
            r_pend_last <= w_re && (r_rd_idx == LAST);
        end
    end

    frame_bank_ram #(
        .I_BW(I_BW),
        .FRAME_LEN(FRAME_LEN)
    ) u_ram (
        .i_clk(clk_i),
        .i_we(w_we),
        .i_waddr({r_wr_bank, r_wr_idx}),
        .i_wdata(bus.data_i),
        .i_re(w_re),
        .i_raddr({r_rd_bank, r_rd_idx}),
        .o_rdata(w_q)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wp <= 1'b0;
            r_rp <= 1'b0;
            r_cnt <= '0;
            r_out_bank <= 1'b0;
        end else if (!en_i) begin
            r_wp <= 1'b0;
            r_rp <= 1'b0;
            r_cnt <= '0;
            r_out_bank <= 1'b0;
        end else begin
            r_wp <= r_wp ^ r_pend;
            r_rp <= r_rp ^ w_pop;
            r_cnt <= r_cnt + 2'(r_pend) - 2'(w_pop);
            r_out_bank <= r_out_bank ^ w_clr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_pend) begin
            r_dat[r_wp] <= w_q;
            r_lst[r_wp] <= r_pend_last;
        end
    end

    assign bus.valid_o = r_cnt != 2'd0;
    assign bus.data_o = bus.valid_o ? O_BW'($signed(r_dat[r_rp])) : '0;
    assign bus.last_o = bus.valid_o && r_lst[r_rp];
    assign err_o = r_err;
endmodule
